// File: rtl/alu_issue.sv
// Initiator for the ALU operand/start/finished handshake: takes one request, sequences the ALU
// (including the DIV start pulse and completion timeout) and holds the captured result until consumed.
module alu_issue #(
  parameter int N            = 32,
  parameter int ALU_OP_COUNT = 4,
  parameter int FLAGS_COUNT  = 5,
  parameter int TIMEOUT      = 64
) (
  input  logic                    CLK,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ALU_OP_COUNT-1:0] req_op,
  input  logic [N-1:0]            req_a,
  input  logic [N-1:0]            req_b,
  input  logic                    req_uns,
  output logic [N-1:0]            alu_a,
  output logic [N-1:0]            alu_b,
  output logic [ALU_OP_COUNT-1:0] alu_opcode,
  output logic                    alu_uns,
  output logic                    alu_start,
  input  logic [N-1:0]            alu_result,
  input  logic [N-1:0]            alu_high,
  input  logic [FLAGS_COUNT-1:0]  alu_flags,
  input  logic                    alu_finished,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [N-1:0]            rsp_result,
  output logic [N-1:0]            rsp_high,
  output logic [FLAGS_COUNT-1:0]  rsp_flags,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    busy
);

  localparam logic [ALU_OP_COUNT-1:0] OP_ADD = ALU_OP_COUNT'(1);
  localparam logic [ALU_OP_COUNT-1:0] OP_SUB = ALU_OP_COUNT'(2);
  localparam logic [ALU_OP_COUNT-1:0] OP_MUL = ALU_OP_COUNT'(3);
  localparam logic [ALU_OP_COUNT-1:0] OP_DIV = ALU_OP_COUNT'(4);
  localparam logic [ALU_OP_COUNT-1:0] OP_NEG = ALU_OP_COUNT'(11);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_WAIT1, S_DGUARD, S_DWAIT, S_RESP
  } state_t;

  state_t                  state_reg, state_next;
  logic [ALU_OP_COUNT-1:0] op_reg;
  logic [N-1:0]            a_reg, b_reg;
  logic                    uns_reg;
  logic [CW-1:0]           cnt_reg;
  logic [N-1:0]            result_reg, high_reg;
  logic [FLAGS_COUNT-1:0]  flags_reg;
  logic                    err_reg, timeout_reg;
  logic                    op_legal;

  assign op_legal = (req_op != '0) && (req_op <= OP_NEG);

  always_ff @(posedge CLK) begin
    if (!rst) state_reg <= S_IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (req_valid) state_next = op_legal ? S_EXEC : S_RESP;
      S_EXEC: begin
        if (op_reg == OP_ADD || op_reg == OP_SUB) state_next = S_RESP;
        else if (op_reg == OP_DIV)                state_next = S_DGUARD;
        else                                      state_next = S_WAIT1;
      end
      S_WAIT1:  state_next = S_RESP;
      S_DGUARD: state_next = S_DWAIT;
      S_DWAIT:  if (alu_finished || cnt_reg == CNT_LAST) state_next = S_RESP;
      S_RESP:   if (rsp_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_reg == S_IDLE);
    busy       = (state_reg != S_IDLE);
    rsp_valid  = (state_reg == S_RESP);
    alu_start  = (state_reg == S_EXEC) && (op_reg == OP_DIV);
    // Opcode 0 outside the active window keeps the ALU's internal registers holding.
    alu_opcode = '0;
    if (state_reg == S_EXEC || state_reg == S_WAIT1 ||
        state_reg == S_DGUARD || state_reg == S_DWAIT)
      alu_opcode = op_reg;
  end

  always_ff @(posedge CLK) begin
    if (!rst) begin
      op_reg      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      uns_reg     <= 1'b0;
      cnt_reg     <= '0;
      result_reg  <= '0;
      high_reg    <= '0;
      flags_reg   <= '0;
      err_reg     <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (req_valid) begin
            if (op_legal) begin
              op_reg  <= req_op;
              a_reg   <= req_a;
              b_reg   <= req_b;
              uns_reg <= req_uns;
            end else begin
              result_reg  <= '0;
              high_reg    <= '0;
              flags_reg   <= '0;
              err_reg     <= 1'b1;
              timeout_reg <= 1'b0;
            end
          end
        end
        S_EXEC: begin
          if (op_reg == OP_ADD || op_reg == OP_SUB) begin
            result_reg  <= alu_result;
            high_reg    <= '0;
            flags_reg   <= alu_flags;
            err_reg     <= 1'b0;
            timeout_reg <= 1'b0;
          end
        end
        S_WAIT1: begin
          result_reg  <= alu_result;
          high_reg    <= (op_reg == OP_MUL) ? alu_high : '0;
          flags_reg   <= alu_flags;
          err_reg     <= 1'b0;
          timeout_reg <= 1'b0;
        end
        // alu_finished may still be high from an earlier op here, so it is not looked at.
        S_DGUARD: cnt_reg <= '0;
        S_DWAIT: begin
          if (alu_finished) begin
            result_reg  <= alu_result;
            high_reg    <= alu_high;
            flags_reg   <= alu_flags;
            err_reg     <= 1'b0;
            timeout_reg <= 1'b0;
          end else if (cnt_reg == CNT_LAST) begin
            result_reg  <= '0;
            high_reg    <= '0;
            flags_reg   <= '0;
            err_reg     <= 1'b0;
            timeout_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_a       = a_reg;
  assign alu_b       = b_reg;
  assign alu_uns     = uns_reg;
  assign rsp_result  = result_reg;
  assign rsp_high    = high_reg;
  assign rsp_flags   = flags_reg;
  assign rsp_err     = err_reg;
  assign rsp_timeout = timeout_reg;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: a behavioural ALU answers the DUT, a vector table drives requests and a
// scoreboard queue holds the expected response for each accepted request.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_uns;
  logic [3:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_opcode;
  logic        alu_uns, alu_start;
  logic [31:0] alu_result, alu_high;
  logic [4:0]  alu_flags;
  logic        alu_finished;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result, rsp_high;
  logic [4:0]  rsp_flags;
  logic        rsp_err, rsp_timeout, busy;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  always #5 clk = ~clk;

  alu_issue #(.N(32), .ALU_OP_COUNT(4), .FLAGS_COUNT(5), .TIMEOUT(64)) dut (
    .CLK(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_uns(req_uns),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_uns(alu_uns),
    .alu_start(alu_start), .alu_result(alu_result), .alu_high(alu_high),
    .alu_flags(alu_flags), .alu_finished(alu_finished),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_high(rsp_high), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .busy(busy)
  );

  // ---------------- behavioural ALU ----------------
  logic [31:0] tmp_result = '0, tmp_high = '0;
  logic [4:0]  tmp_flags = '0;
  logic        finished_reg = 1'b0, start_d = 1'b0;
  logic        div_hang = 1'b0;
  int          div_cnt = 0;
  logic [63:0] prod;
  logic [31:0] reg_val, div_q, div_r;

  function automatic logic [4:0] mk_flags(input logic [31:0] r);
    return {1'b0, (!r[31] && (r != 32'd0)), 2'b00, (r == 32'd0)};
  endfunction

  always_comb begin
    prod = alu_uns ? ({32'd0, alu_a} * {32'd0, alu_b})
                   : ($signed({{32{alu_a[31]}}, alu_a}) * $signed({{32{alu_b[31]}}, alu_b}));
    div_q = 32'hFFFF_FFFF;
    div_r = alu_a;
    if (alu_b != 32'd0) begin
      div_q = alu_uns ? alu_a / alu_b : 32'($signed(alu_a) / $signed(alu_b));
      div_r = alu_uns ? alu_a % alu_b : 32'($signed(alu_a) % $signed(alu_b));
    end
    case (alu_opcode)
      4'd5:    reg_val = alu_a & alu_b;
      4'd6:    reg_val = alu_a | alu_b;
      4'd7:    reg_val = alu_a ^ alu_b;
      4'd8:    reg_val = ~alu_a;
      4'd9:    reg_val = alu_a << alu_b[4:0];
      4'd10:   reg_val = alu_uns ? alu_a >> alu_b[4:0] : 32'($signed(alu_a) >>> alu_b[4:0]);
      4'd11:   reg_val = 32'd0 - alu_a;
      default: reg_val = 32'd0;
    endcase
    alu_result = tmp_result;
    alu_high   = tmp_high;
    alu_flags  = tmp_flags;
    if (alu_opcode == 4'd1) begin
      alu_result = alu_a + alu_b;
      alu_flags  = mk_flags(alu_a + alu_b);
    end else if (alu_opcode == 4'd2) begin
      alu_result = alu_a - alu_b;
      alu_flags  = mk_flags(alu_a - alu_b);
    end
  end

  assign alu_finished = finished_reg;

  // finished is cleared one cycle after start, so it is stale during DGUARD.
  always @(posedge clk) begin
    start_d <= alu_start;
    if (start_d) finished_reg <= 1'b0;
    if (alu_opcode == 4'd3) begin
      tmp_result   <= prod[31:0];
      tmp_high     <= prod[63:32];
      tmp_flags    <= mk_flags(prod[31:0]);
      finished_reg <= 1'b1;
    end else if (alu_opcode >= 4'd5 && alu_opcode <= 4'd11) begin
      tmp_result <= reg_val;
      tmp_high   <= 32'hDEAD_BEEF;
      tmp_flags  <= mk_flags(reg_val);
    end
    if (alu_start && !div_hang) begin
      div_cnt <= 4;
    end else if (div_cnt != 0) begin
      div_cnt <= div_cnt - 1;
      if (div_cnt == 1) begin
        tmp_result   <= div_q;
        tmp_high     <= div_r;
        tmp_flags    <= mk_flags(div_q);
        finished_reg <= 1'b1;
      end
    end
  end

  always @(negedge clk) if (alu_start === 1'b1) start_cnt <= start_cnt + 1;

  // ---------------- checking ----------------
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        uns, hang;
    int          hold;
    logic [31:0] res, high;
    logic [4:0]  flags;
    logic        err, tmo;
    int          lat, starts;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic uns, input logic hang, input int hold,
                              input logic [31:0] res, input logic [31:0] high, input logic [4:0] flags,
                              input logic err, input logic tmo, input int lat, input int starts);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.uns = uns; v.hang = hang; v.hold = hold;
    v.res = res; v.high = high; v.flags = flags; v.err = err; v.tmo = tmo;
    v.lat = lat; v.starts = starts;
    return v;
  endfunction

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    vec_t        e;
    int          lat;
    int          start_base;
    logic [70:0] snap;
    div_hang = v.hang;
    @(negedge clk);
    check("req_ready_idle", 80'(req_ready), 80'(1));
    req_valid = 1'b1; req_op = v.op; req_a = v.a; req_b = v.b; req_uns = v.uns;
    start_base = start_cnt;
    exp_q.push_back(v);
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 4'd0;
    lat = 1;
    forever begin
      @(negedge clk);
      if (rsp_valid || lat >= 300) break;
      lat++;
    end
    check("rsp_valid_seen", 80'(rsp_valid), 80'(1));
    snap = {rsp_result, rsp_high, rsp_flags, rsp_err, rsp_timeout};
    if (v.hold > 0) begin
      req_valid = 1'b1; req_op = 4'd1; req_a = 32'd100; req_b = 32'd200;
      for (int k = 0; k < v.hold; k++) begin
        @(negedge clk);
        check("stall_rsp_stable", 80'({rsp_result, rsp_high, rsp_flags, rsp_err, rsp_timeout}), 80'(snap));
        check("stall_req_ready", 80'(req_ready), 80'(0));
        check("stall_rsp_valid", 80'(rsp_valid), 80'(1));
      end
      req_valid = 1'b0; req_op = 4'd0;
    end
    e = exp_q.pop_front();
    check("rsp_result", 80'(rsp_result), 80'(e.res));
    check("rsp_high", 80'(rsp_high), 80'(e.high));
    check("rsp_flags", 80'(rsp_flags), 80'(e.flags));
    check("rsp_err", 80'(rsp_err), 80'(e.err));
    check("rsp_timeout", 80'(rsp_timeout), 80'(e.tmo));
    check("resp_opcode_idle", 80'(alu_opcode), 80'(0));
    check("latency", 80'(lat), 80'(e.lat));
    check("start_pulses", 80'(start_cnt - start_base), 80'(e.starts));
    $display("txn op=%0d a=0x%0h b=0x%0h -> result=0x%0h high=0x%0h flags=%b err=%b tmo=%b lat=%0d",
             v.op, v.a, v.b, rsp_result, rsp_high, rsp_flags, rsp_err, rsp_timeout, lat);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("rsp_valid_drop", 80'(rsp_valid), 80'(0));
    check("busy_after_consume", 80'(busy), 80'(0));
    check("rsp_result_retained", 80'(rsp_result), 80'(e.res));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // op, a, b, uns, hang, hold, result, high, flags, err, tmo, latency, start pulses
    vecs.push_back(mk(4'd1, 32'd5, 32'd7, 1'b0, 1'b0, 0, 32'd12, 32'd0, 5'b01000, 1'b0, 1'b0, 2, 0));
    vecs.push_back(mk(4'd2, 32'd3, 32'd3, 1'b0, 1'b0, 0, 32'd0, 32'd0, 5'b00001, 1'b0, 1'b0, 2, 0));
    vecs.push_back(mk(4'd5, 32'h0000_F0F0, 32'h0000_0FF0, 1'b0, 1'b0, 0, 32'h0000_00F0, 32'd0, 5'b01000, 1'b0, 1'b0, 3, 0));
    vecs.push_back(mk(4'd3, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 0, 32'd0, 32'd1, 5'b00001, 1'b0, 1'b0, 3, 0));
    vecs.push_back(mk(4'd4, 32'd100, 32'd7, 1'b0, 1'b0, 0, 32'd14, 32'd2, 5'b01000, 1'b0, 1'b0, 7, 1));
    vecs.push_back(mk(4'd6, 32'h0000_1200, 32'h0000_0034, 1'b0, 1'b0, 0, 32'h0000_1234, 32'd0, 5'b01000, 1'b0, 1'b0, 3, 0));
    vecs.push_back(mk(4'd7, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b0, 1'b0, 5, 32'hF0F0_0F0F, 32'd0, 5'b00000, 1'b0, 1'b0, 3, 0));
    vecs.push_back(mk(4'd12, 32'd1, 32'd2, 1'b0, 1'b0, 0, 32'd0, 32'd0, 5'b00000, 1'b1, 1'b0, 1, 0));
    vecs.push_back(mk(4'd8, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 0, 32'd0, 32'd0, 5'b00001, 1'b0, 1'b0, 3, 0));
    vecs.push_back(mk(4'd9, 32'd1, 32'd4, 1'b0, 1'b0, 0, 32'd16, 32'd0, 5'b01000, 1'b0, 1'b0, 3, 0));
    vecs.push_back(mk(4'd10, 32'h8000_0000, 32'd4, 1'b0, 1'b0, 0, 32'hF800_0000, 32'd0, 5'b00000, 1'b0, 1'b0, 3, 0));
    vecs.push_back(mk(4'd10, 32'h8000_0000, 32'd4, 1'b1, 1'b0, 0, 32'h0800_0000, 32'd0, 5'b01000, 1'b0, 1'b0, 3, 0));
    vecs.push_back(mk(4'd11, 32'd5, 32'd0, 1'b0, 1'b0, 0, 32'hFFFF_FFFB, 32'd0, 5'b00000, 1'b0, 1'b0, 3, 0));
    vecs.push_back(mk(4'd0, 32'd9, 32'd9, 1'b0, 1'b0, 0, 32'd0, 32'd0, 5'b00000, 1'b1, 1'b0, 1, 0));
    vecs.push_back(mk(4'd15, 32'd9, 32'd9, 1'b0, 1'b0, 0, 32'd0, 32'd0, 5'b00000, 1'b1, 1'b0, 1, 0));
    // DIV whose ALU never finishes: 3 cycles to DWAIT plus 64 DWAIT cycles.
    vecs.push_back(mk(4'd4, 32'd50, 32'd5, 1'b0, 1'b1, 0, 32'd0, 32'd0, 5'b00000, 1'b0, 1'b1, 67, 1));
    vecs.push_back(mk(4'd4, 32'd9, 32'd3, 1'b0, 1'b0, 0, 32'd3, 32'd0, 5'b01000, 1'b0, 1'b0, 7, 1));

    rst = 1'b0; req_valid = 1'b0; req_op = 4'd0; req_a = '0; req_b = '0; req_uns = 1'b0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", 80'(req_ready), 80'(1));
    check("reset_busy", 80'(busy), 80'(0));
    check("reset_rsp_valid", 80'(rsp_valid), 80'(0));
    check("reset_alu_start", 80'(alu_start), 80'(0));
    check("reset_alu_outputs", 80'({alu_a, alu_b, alu_opcode, alu_uns}), 80'(0));
    check("reset_rsp_fields", 80'({rsp_result, rsp_high, rsp_flags, rsp_err, rsp_timeout}), 80'(0));
    rst = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while the divider is outstanding: the op is dropped without a response.
    div_hang = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'd4; req_a = 32'd77; req_b = 32'd7; req_uns = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 4'd0;
    repeat (6) @(negedge clk);
    check("dwait_busy", 80'(busy), 80'(1));
    check("dwait_rsp_valid", 80'(rsp_valid), 80'(0));
    check("dwait_opcode", 80'(alu_opcode), 80'(4));
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midreset_busy", 80'(busy), 80'(0));
    check("midreset_alu_start", 80'(alu_start), 80'(0));
    check("midreset_rsp_valid", 80'(rsp_valid), 80'(0));
    check("midreset_req_ready", 80'(req_ready), 80'(1));
    check("midreset_opcode", 80'(alu_opcode), 80'(0));
    $display("txn mid-op reset during DIV: busy=%b rsp_valid=%b", busy, rsp_valid);
    rst = 1'b1;
    run_vec(mk(4'd1, 32'd1, 32'd1, 1'b0, 1'b0, 0, 32'd2, 32'd0, 5'b01000, 1'b0, 1'b0, 2, 0));
    run_vec(mk(4'd4, 32'd81, 32'd9, 1'b0, 1'b0, 0, 32'd9, 32'd0, 5'b01000, 1'b0, 1'b0, 7, 1));

    check("scoreboard_empty", 80'(exp_q.size()), 80'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
